// File: rtl/uart_rx_bit_checker_if.sv
// ---------------------------------------------------------------------------
// uart_rx_bit_checker_if
// Purpose : Bundles the check request coming from the RX FSM and bit counter,
//           and the check results going back to the FSM and status logic.
// Signals :
//   check_en     check window active
//   check_type   00 start, 01 parity, 10 stop, 11 reserved
//   rx_in        synchronised serial input
//   edge_count   oversample edge index within the current bit
//   prescale     oversample ratio
//   par_type     0 even, 1 odd
//   par_data     received data word for the parity compare
//   clr_counts   synchronous clear of all error counters
//   sampled_bit  majority-voted bit value
//   check_done   one-cycle pulse when a decision is made
//   start_glitch start bit sampled high
//   par_err      parity mismatch
//   stop_err     stop bit sampled low
//   glitch_cnt / par_err_cnt / stop_err_cnt  saturating error counters
// Modports: master drives the request side, slave is the checker itself.
// ---------------------------------------------------------------------------
interface uart_rx_bit_checker_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6,
   parameter int EDGE_W     = 6,
   parameter int CNT_W      = 8
);
   logic                  check_en;
   logic [1:0]            check_type;
   logic                  rx_in;
   logic [EDGE_W-1:0]     edge_count;
   logic [PRESC_W-1:0]    prescale;
   logic                  par_type;
   logic [DATA_WIDTH-1:0] par_data;
   logic                  clr_counts;

   logic                  sampled_bit;
   logic                  check_done;
   logic                  start_glitch;
   logic                  par_err;
   logic                  stop_err;
   logic [CNT_W-1:0]      glitch_cnt;
   logic [CNT_W-1:0]      par_err_cnt;
   logic [CNT_W-1:0]      stop_err_cnt;

   modport master (
      output check_en, check_type, rx_in, edge_count, prescale,
             par_type, par_data, clr_counts,
      input  sampled_bit, check_done, start_glitch, par_err, stop_err,
             glitch_cnt, par_err_cnt, stop_err_cnt
   );

   modport slave (
      input  check_en, check_type, rx_in, edge_count, prescale,
             par_type, par_data, clr_counts,
      output sampled_bit, check_done, start_glitch, par_err, stop_err,
             glitch_cnt, par_err_cnt, stop_err_cnt
   );
endinterface

// File: rtl/uart_rx_bit_checker.sv
// ---------------------------------------------------------------------------
// uart_rx_bit_checker
// Purpose : Unified UART RX bit checker. Takes three samples around mid-bit,
//           majority-votes them and performs the start, parity or stop check
//           selected by the RX FSM. Flags are sticky per check type and feed
//           saturating error counters.
// Ports   :
//   clk  clock
//   rst  synchronous active-low reset
//   bus  uart_rx_bit_checker_if.slave (request inputs, result outputs)
// ---------------------------------------------------------------------------
module uart_rx_bit_checker #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6,
   parameter int EDGE_W     = 6,
   parameter int CNT_W      = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   uart_rx_bit_checker_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, S1, S2, S3} state_t;
   typedef enum logic [1:0] {CHK_START, CHK_PARITY, CHK_STOP, CHK_RSVD} chk_t;

   state_t            state, state_nxt;
   chk_t              lat_type;
   logic              v0, v1, v2;
   logic              cap0, cap1, cap2, decide;
   logic              maj, par_exp;
   logic [EDGE_W-1:0] half, tgt_m1, tgt_p1, tgt_p2;

   logic              sampled_q, done_q, glitch_q, par_err_q, stop_err_q;
   logic [CNT_W-1:0]  glitch_cnt_q, par_cnt_q, stop_cnt_q;

   // Half the effective prescale. Clearing bit 0 then halving is the same as
   // dropping bit 0; ratios below 4 are clamped so H never drops below 2 and
   // H-1 stays a valid edge index.
   always_comb begin
      half = EDGE_W'(bus.prescale[PRESC_W-1:1]);
      if (half < EDGE_W'(2)) begin
         half = EDGE_W'(2);
      end
      tgt_m1 = half - EDGE_W'(1);
      tgt_p1 = half + EDGE_W'(1);
      tgt_p2 = half + EDGE_W'(2);
   end

   // State register for the sampling sequencer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Sequencer: one state per mid-bit sample, then a decision at H+2.
   // Each state waits for its own edge index; dropping check_en after the
   // first sample abandons the window with no decision.
   always_comb begin
      state_nxt = state;
      cap0      = 1'b0;
      cap1      = 1'b0;
      cap2      = 1'b0;
      decide    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.check_en && bus.edge_count == tgt_m1) begin
               state_nxt = S1;
               cap0      = 1'b1;
            end
         end
         S1: begin
            if (!bus.check_en) begin
               state_nxt = IDLE;
            end else if (bus.edge_count == half) begin
               state_nxt = S2;
               cap1      = 1'b1;
            end
         end
         S2: begin
            if (!bus.check_en) begin
               state_nxt = IDLE;
            end else if (bus.edge_count == tgt_p1) begin
               state_nxt = S3;
               cap2      = 1'b1;
            end
         end
         S3: begin
            if (!bus.check_en) begin
               state_nxt = IDLE;
            end else if (bus.edge_count == tgt_p2) begin
               state_nxt = IDLE;
               decide    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Vote of the three captured samples and the parity the data word should
   // produce; par_data is only looked at on the decision cycle.
   always_comb begin
      maj     = (v0 & v1) | (v0 & v2) | (v1 & v2);
      par_exp = bus.par_type ? ~^bus.par_data : ^bus.par_data;
   end

   // Sample capture, latched check type, voted bit, done pulse and sticky
   // flags. The check type is frozen at the first sample so the FSM may move
   // on to the next request while the vote is still in progress.
   always_ff @(posedge clk) begin
      if (!rst) begin
         v0         <= 1'b0;
         v1         <= 1'b0;
         v2         <= 1'b0;
         lat_type   <= CHK_START;
         sampled_q  <= 1'b0;
         done_q     <= 1'b0;
         glitch_q   <= 1'b0;
         par_err_q  <= 1'b0;
         stop_err_q <= 1'b0;
      end else begin
         done_q <= decide;
         if (cap0) begin
            v0       <= bus.rx_in;
            lat_type <= chk_t'(bus.check_type);
         end
         if (cap1) begin
            v1 <= bus.rx_in;
         end
         if (cap2) begin
            v2 <= bus.rx_in;
         end
         if (decide) begin
            sampled_q <= maj;
            case (lat_type)
               CHK_START:  glitch_q   <= maj;
               CHK_PARITY: par_err_q  <= (maj != par_exp);
               CHK_STOP:   stop_err_q <= ~maj;
               default:    ;
            endcase
         end
      end
   end

   // Saturating error counters. A clear wins over a simultaneous increment
   // so software never sees a stale count after clearing.
   always_ff @(posedge clk) begin
      if (!rst || bus.clr_counts) begin
         glitch_cnt_q <= '0;
         par_cnt_q    <= '0;
         stop_cnt_q   <= '0;
      end else if (decide) begin
         if (lat_type == CHK_START && maj && glitch_cnt_q != '1) begin
            glitch_cnt_q <= glitch_cnt_q + CNT_W'(1);
         end
         if (lat_type == CHK_PARITY && (maj != par_exp) && par_cnt_q != '1) begin
            par_cnt_q <= par_cnt_q + CNT_W'(1);
         end
         if (lat_type == CHK_STOP && !maj && stop_cnt_q != '1) begin
            stop_cnt_q <= stop_cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.sampled_bit  = sampled_q;
   assign bus.check_done   = done_q;
   assign bus.start_glitch = glitch_q;
   assign bus.par_err      = par_err_q;
   assign bus.stop_err     = stop_err_q;
   assign bus.glitch_cnt   = glitch_cnt_q;
   assign bus.par_err_cnt  = par_cnt_q;
   assign bus.stop_err_cnt = stop_cnt_q;

endmodule

// File: tb/tb_uart_rx_bit_checker.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_bit_checker
// Purpose : Self-checking bench for uart_rx_bit_checker. Each scenario task
//           updates a reference model, pushes the expected decision into a
//           queue, drives one check window and compares what the DUT
//           reported against the queued expectation.
// ---------------------------------------------------------------------------
module tb_uart_rx_bit_checker;

   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [5:0] de;
      logic       sb;
      logic       sg;
      logic       pe;
      logic       se;
      logic [1:0] gc;
      logic [1:0] pc;
      logic [1:0] sc;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int total = 0;
   int bad   = 0;

   obs_t exp_q[$];
   obs_t obs_q[$];

   logic m_sb, m_sg, m_pe, m_se;
   int   m_gc, m_pc, m_sc;

   uart_rx_bit_checker_if #(.DATA_WIDTH(8), .PRESC_W(6), .EDGE_W(6), .CNT_W(CNT_W)) bus ();

   uart_rx_bit_checker #(.DATA_WIDTH(8), .PRESC_W(6), .EDGE_W(6), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   function automatic int calc_h(input int presc);
      int pe;
      pe = (presc / 2) * 2;
      if (pe < 4) pe = 4;
      return pe / 2;
   endfunction

   function automatic obs_t snap(input int de);
      obs_t o;
      o.de = 6'(de);
      o.sb = bus.sampled_bit;
      o.sg = bus.start_glitch;
      o.pe = bus.par_err;
      o.se = bus.stop_err;
      o.gc = bus.glitch_cnt;
      o.pc = bus.par_err_cnt;
      o.sc = bus.stop_err_cnt;
      return o;
   endfunction

   function automatic obs_t model_now(input int de);
      obs_t o;
      o.de = 6'(de);
      o.sb = m_sb;
      o.sg = m_sg;
      o.pe = m_pe;
      o.se = m_se;
      o.gc = 2'(m_gc);
      o.pc = 2'(m_pc);
      o.sc = 2'(m_sc);
      return o;
   endfunction

   // Reference model of one decision; pushes the expected outputs.
   task automatic model_decide(input logic [1:0] ty, input logic [2:0] smp, input int presc,
                               input logic pt, input logic [7:0] pd, input bit clr);
      logic maj;
      logic par_exp;
      maj     = (smp[2] & smp[1]) | (smp[2] & smp[0]) | (smp[1] & smp[0]);
      par_exp = pt ? ~^pd : ^pd;
      m_sb    = maj;
      case (ty)
         2'b00: begin
            m_sg = maj;
            if (maj && m_gc < CNT_MAX) m_gc++;
         end
         2'b01: begin
            m_pe = (maj != par_exp);
            if (m_pe && m_pc < CNT_MAX) m_pc++;
         end
         2'b10: begin
            m_se = ~maj;
            if (!maj && m_sc < CNT_MAX) m_sc++;
         end
         default: ;
      endcase
      if (clr) begin
         m_gc = 0;
         m_pc = 0;
         m_sc = 0;
      end
      exp_q.push_back(model_now(calc_h(presc) + 2));
   endtask

   task automatic idle_inputs();
      bus.check_en   = 1'b0;
      bus.check_type = 2'b00;
      bus.rx_in      = 1'b1;
      bus.edge_count = '0;
      bus.prescale   = 6'd8;
      bus.par_type   = 1'b0;
      bus.par_data   = '0;
      bus.clr_counts = 1'b0;
   endtask

   // Drives one bit window (edges 0..H+3) plus an idle tail, recording every
   // check_done pulse together with the edge index that caused it.
   task automatic drive_window(input logic [1:0] ty0, input logic [1:0] ty1, input logic [2:0] smp,
                               input int presc, input int abort_edge, input logic pt,
                               input logic [7:0] pd, input bit clr, output int n);
      int h;
      int last_e;
      h      = calc_h(presc);
      n      = 0;
      last_e = 0;
      obs_q.delete();
      for (int e = 0; e <= h + 5; e++) begin
         @(posedge clk);
         #1;
         if (bus.check_done === 1'b1) begin
            n++;
            obs_q.push_back(snap(last_e));
         end
         if (e <= h + 3) begin
            bus.check_en   = (abort_edge < 0) || (e < abort_edge);
            bus.check_type = (e <= h - 1) ? ty0 : ty1;
            bus.edge_count = 6'(e);
            bus.prescale   = 6'(presc);
            bus.par_type   = pt;
            bus.par_data   = (e == h + 2) ? pd : 8'($urandom);
            bus.clr_counts = clr && (e == h + 2);
            if (e == h - 1)      bus.rx_in = smp[2];
            else if (e == h)     bus.rx_in = smp[1];
            else if (e == h + 1) bus.rx_in = smp[0];
            else                 bus.rx_in = 1'($urandom);
            last_e = e;
         end else begin
            bus.check_en   = 1'b0;
            bus.clr_counts = 1'b0;
            bus.edge_count = 6'($urandom);
            bus.rx_in      = 1'($urandom);
         end
      end
   endtask

   task automatic test_reset();
      obs_t ob;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.check_en   = 1'($urandom);
         bus.check_type = 2'($urandom);
         bus.rx_in      = 1'($urandom);
         bus.edge_count = 6'($urandom);
         bus.prescale   = 6'($urandom);
         bus.par_type   = 1'($urandom);
         bus.par_data   = 8'($urandom);
         bus.clr_counts = 1'($urandom);
         @(posedge clk);
         #1;
         ob = snap(0);
         total++;
         if (ob !== '0 || bus.check_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_hold: got %h done=%b want 0000 done=0", ob, bus.check_done);
         end
      end
      idle_inputs();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         ob = snap(0);
         total++;
         if (ob !== '0 || bus.check_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release: got %h done=%b want 0000 done=0", ob, bus.check_done);
         end
      end
      m_sb = 0; m_sg = 0; m_pe = 0; m_se = 0;
      m_gc = 0; m_pc = 0; m_sc = 0;
   endtask

   task automatic test_start_glitch();
      logic [2:0] smp_tab[2] = '{3'b111, 3'b001};
      obs_t ex, ob;
      int   n;
      foreach (smp_tab[i]) begin
         model_decide(2'b00, smp_tab[i], 8, 1'b0, 8'h00, 1'b0);
         drive_window(2'b00, 2'b00, smp_tab[i], 8, -1, 1'b0, 8'h00, 1'b0, n);
         ex = exp_q.pop_front();
         total++;
         if (n != 1) begin
            bad++;
            $display("[TB] FAIL start_pulses: got %0d pulses want 1", n);
         end else begin
            ob = obs_q.pop_front();
            total++;
            if (ob !== ex) begin
               bad++;
               $display("[TB] FAIL start_result[%0d]: got %h want %h", i, ob, ex);
            end
         end
      end
   endtask

   task automatic test_parity();
      logic [2:0] smp_tab[3] = '{3'b000, 3'b010, 3'b111};
      logic       pt_tab[3]  = '{1'b0, 1'b1, 1'b0};
      obs_t ex, ob;
      int   n;
      foreach (smp_tab[i]) begin
         model_decide(2'b01, smp_tab[i], 16, pt_tab[i], 8'hA5, 1'b0);
         drive_window(2'b01, 2'b01, smp_tab[i], 16, -1, pt_tab[i], 8'hA5, 1'b0, n);
         ex = exp_q.pop_front();
         total++;
         if (n != 1) begin
            bad++;
            $display("[TB] FAIL parity_pulses: got %0d pulses want 1", n);
         end else begin
            ob = obs_q.pop_front();
            total++;
            if (ob !== ex) begin
               bad++;
               $display("[TB] FAIL parity_result[%0d]: got %h want %h", i, ob, ex);
            end
         end
      end
   endtask

   task automatic test_stop();
      logic [2:0] smp_tab[2] = '{3'b101, 3'b010};
      obs_t ex, ob;
      int   n;
      foreach (smp_tab[i]) begin
         model_decide(2'b10, smp_tab[i], 8, 1'b0, 8'h00, 1'b0);
         drive_window(2'b10, 2'b10, smp_tab[i], 8, -1, 1'b0, 8'h00, 1'b0, n);
         ex = exp_q.pop_front();
         total++;
         if (n != 1) begin
            bad++;
            $display("[TB] FAIL stop_pulses: got %0d pulses want 1", n);
         end else begin
            ob = obs_q.pop_front();
            total++;
            if (ob !== ex) begin
               bad++;
               $display("[TB] FAIL stop_result[%0d]: got %h want %h", i, ob, ex);
            end
         end
      end
   endtask

   task automatic test_abort();
      obs_t ex, ob;
      int   n;
      drive_window(2'b00, 2'b00, 3'b111, 8, 4, 1'b0, 8'h00, 1'b0, n);
      total++;
      if (n != 0) begin
         bad++;
         $display("[TB] FAIL abort_pulses: got %0d pulses want 0", n);
      end
      ob = snap(0);
      ex = model_now(0);
      total++;
      if (ob !== ex) begin
         bad++;
         $display("[TB] FAIL abort_flags: got %h want %h", ob, ex);
      end
      model_decide(2'b00, 3'b110, 8, 1'b0, 8'h00, 1'b0);
      drive_window(2'b00, 2'b00, 3'b110, 8, -1, 1'b0, 8'h00, 1'b0, n);
      ex = exp_q.pop_front();
      total++;
      if (n != 1) begin
         bad++;
         $display("[TB] FAIL abort_next_pulses: got %0d pulses want 1", n);
      end else begin
         ob = obs_q.pop_front();
         total++;
         if (ob !== ex) begin
            bad++;
            $display("[TB] FAIL abort_next_result: got %h want %h", ob, ex);
         end
      end
   endtask

   task automatic test_type_latch();
      logic [1:0] ty0_tab[3] = '{2'b10, 2'b11, 2'b01};
      logic [1:0] ty1_tab[3] = '{2'b00, 2'b10, 2'b11};
      logic [2:0] smp_tab[3] = '{3'b000, 3'b111, 3'b100};
      obs_t ex, ob;
      int   n;
      foreach (ty0_tab[i]) begin
         model_decide(ty0_tab[i], smp_tab[i], 10, 1'b1, 8'h3C, 1'b0);
         drive_window(ty0_tab[i], ty1_tab[i], smp_tab[i], 10, -1, 1'b1, 8'h3C, 1'b0, n);
         ex = exp_q.pop_front();
         total++;
         if (n != 1) begin
            bad++;
            $display("[TB] FAIL latch_pulses: got %0d pulses want 1", n);
         end else begin
            ob = obs_q.pop_front();
            total++;
            if (ob !== ex) begin
               bad++;
               $display("[TB] FAIL latch_result[%0d]: got %h want %h", i, ob, ex);
            end
         end
      end
   endtask

   task automatic test_saturation();
      obs_t ex, ob;
      int   n;
      bit   clr;
      for (int i = 0; i < 6; i++) begin
         clr = (i == 5);
         model_decide(2'b10, 3'b001, 8, 1'b0, 8'h00, clr);
         drive_window(2'b10, 2'b10, 3'b001, 8, -1, 1'b0, 8'h00, clr, n);
         ex = exp_q.pop_front();
         total++;
         if (n != 1) begin
            bad++;
            $display("[TB] FAIL sat_pulses: got %0d pulses want 1", n);
         end else begin
            ob = obs_q.pop_front();
            total++;
            if (ob !== ex) begin
               bad++;
               $display("[TB] FAIL sat_result[%0d]: got %h want %h", i, ob, ex);
            end
         end
      end
   endtask

   task automatic test_clamp();
      int         presc_tab[3] = '{2, 3, 9};
      logic [2:0] smp_tab[3]   = '{3'b011, 3'b100, 3'b111};
      obs_t ex, ob;
      int   n;
      foreach (presc_tab[i]) begin
         model_decide(2'b00, smp_tab[i], presc_tab[i], 1'b0, 8'h00, 1'b0);
         drive_window(2'b00, 2'b00, smp_tab[i], presc_tab[i], -1, 1'b0, 8'h00, 1'b0, n);
         ex = exp_q.pop_front();
         total++;
         if (n != 1) begin
            bad++;
            $display("[TB] FAIL clamp_pulses: got %0d pulses want 1", n);
         end else begin
            ob = obs_q.pop_front();
            total++;
            if (ob !== ex) begin
               bad++;
               $display("[TB] FAIL clamp_result[%0d]: got %h want %h", i, ob, ex);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int         presc_tab[6] = '{4, 7, 8, 12, 16, 20};
      logic [1:0] ty;
      logic [2:0] smp;
      logic       pt;
      logic [7:0] pd;
      int         presc;
      obs_t ex, ob;
      int   n;
      for (int i = 0; i < 10; i++) begin
         ty    = 2'($urandom);
         smp   = 3'($urandom);
         pt    = 1'($urandom);
         pd    = 8'($urandom);
         presc = presc_tab[$urandom_range(0, 5)];
         model_decide(ty, smp, presc, pt, pd, 1'b0);
         drive_window(ty, 2'($urandom), smp, presc, -1, pt, pd, 1'b0, n);
         ex = exp_q.pop_front();
         total++;
         if (n != 1) begin
            bad++;
            $display("[TB] FAIL b2b_pulses: got %0d pulses want 1", n);
         end else begin
            ob = obs_q.pop_front();
            total++;
            if (ob !== ex) begin
               bad++;
               $display("[TB] FAIL b2b_result[%0d]: got %h want %h (ty=%b smp=%b P=%0d)",
                        i, ob, ex, ty, smp, presc);
            end
         end
      end
   endtask

   // Scenario sequence; each task does its own comparisons.
   initial begin
      idle_inputs();
      test_reset();
      test_start_glitch();
      test_parity();
      test_stop();
      test_abort();
      test_type_latch();
      test_saturation();
      test_clamp();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
